// File: rtl/matmul_seq_ctrl.sv
// Sequencer between a valid/ready element stream and one pipelined N x N matrix_mult array.
// Loads A then B, holds them on the array for LAT cycles, snapshots the results and streams them out.
module matmul_seq_ctrl #(
  parameter int N        = 3,
  parameter int BitWidth = 8,
  parameter int LAT      = 2 * N + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BitWidth-1:0]   in_data,
  output logic                  mm_enable,
  output logic [BitWidth-1:0]   mm_a [0:N*N-1],
  output logic [BitWidth-1:0]   mm_b [0:N*N-1],
  input  logic [2*BitWidth-1:0] mm_result [0:N*N-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BitWidth-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NN     = N * N;
  localparam int BEAT_W = $clog2(2 * NN + 1);
  localparam int CYC_W  = $clog2(LAT + 1);
  localparam int IDX_W  = $clog2(NN + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * NN - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(LAT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NN - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_CAPTURE,
    S_STREAM
  } state_t;

  state_t                state, state_nxt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [CYC_W-1:0]      cyc_cnt;
  logic [IDX_W-1:0]      out_idx;
  logic                  armed;
  logic [2*BitWidth-1:0] res_buf [0:NN-1];
  logic                  in_hs;
  logic                  out_hs;

  // armed keeps in_ready low for the whole reset window, rising the cycle after release.
  assign in_ready  = armed && (state == S_LOAD);
  assign mm_enable = (state == S_COMPUTE);
  assign out_valid = (state == S_STREAM);
  assign busy      = (state != S_LOAD);
  assign out_last  = out_valid && (out_idx == LAST_IDX);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NN; i++) begin
      if (out_valid && (out_idx == IDX_W'(i))) out_data = res_buf[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (in_hs && (beat_cnt == LAST_BEAT)) state_nxt = S_COMPUTE;
      S_COMPUTE: if (cyc_cnt == LAST_CYC) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_STREAM;
      S_STREAM:  if (out_hs && (out_idx == LAST_IDX)) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
    if (flush) state_nxt = S_LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_LOAD;
      beat_cnt <= '0;
      cyc_cnt  <= '0;
      out_idx  <= '0;
      armed    <= 1'b0;
      // NOTE: the operand and result arrays are reset because they drive the array and out_data directly.
      for (int i = 0; i < NN; i++) begin
        mm_a[i]    <= '0;
        mm_b[i]    <= '0;
        res_buf[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (flush) begin
        beat_cnt <= '0;
        cyc_cnt  <= '0;
        out_idx  <= '0;
      end else begin
        if (in_hs) begin
          for (int i = 0; i < NN; i++) begin
            if (beat_cnt == BEAT_W'(i))      mm_a[i] <= in_data;
            if (beat_cnt == BEAT_W'(NN + i)) mm_b[i] <= in_data;
          end
          beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
        if (state == S_COMPUTE) cyc_cnt <= (cyc_cnt == LAST_CYC) ? '0 : cyc_cnt + 1'b1;
        if (state == S_CAPTURE) begin
          for (int i = 0; i < NN; i++) res_buf[i] <= mm_result[i];
        end
        if (out_hs) out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
      end
    end
  end

endmodule
